// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, fixed 33-cycle latency from start to valid.
module mdu_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        valid,
  output logic [31:0] C
);

  // Handshake: start is accepted only while busy is low (and flush is low);
  // busy stays high until the cycle after the one-cycle valid strobe, and C
  // holds the last delivered result until the next one is written.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic [31:0] a_mag_q, a_mag_d;
  logic [31:0] b_mag_q, b_mag_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] c_q, c_d;
  logic        valid_q, valid_d;

  // Operand conditioning for the request being sampled
  logic        signed_a_in, signed_b_in;
  logic        neg_a_in, neg_b_in;
  logic [31:0] a_abs_in, b_abs_in;

  always_comb begin
    signed_a_in = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    signed_b_in = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg_a_in    = signed_a_in & A[31];
    neg_b_in    = signed_b_in & B[31];
    a_abs_in    = neg_a_in ? (~A + 32'd1) : A;
    b_abs_in    = neg_b_in ? (~B + 32'd1) : B;
  end

  // One multiply iteration: conditional add into hi, then 65-bit right shift
  logic [32:0] mul_sum;
  logic [31:0] mul_hi_nxt, mul_lo_nxt;

  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : 33'd0);
    mul_hi_nxt = mul_sum[32:1];
    mul_lo_nxt = {mul_sum[0], lo_q[31:1]};
  end

  // One restoring-divide iteration on {rem, quo}
  logic [32:0] rem_sh, rem_diff;
  logic        div_ok;
  logic [31:0] div_hi_nxt, div_lo_nxt;

  always_comb begin
    rem_sh     = {hi_q, lo_q[31]};
    rem_diff   = rem_sh - {1'b0, b_mag_q};
    div_ok     = ~rem_diff[32];
    div_hi_nxt = div_ok ? rem_diff[31:0] : rem_sh[31:0];
    div_lo_nxt = {lo_q[30:0], div_ok};
  end

  // Sign correction and result selection used in FIX
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, a_orig, result;

  always_comb begin
    prod_s = (sign_a_q ^ sign_b_q) ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
    quo_s  = (sign_a_q ^ sign_b_q) ? (~lo_q + 32'd1) : lo_q;
    rem_s  = sign_a_q ? (~hi_q + 32'd1) : hi_q;
    a_orig = sign_a_q ? (~a_mag_q + 32'd1) : a_mag_q;
    result = '0;
    case (op_q)
      3'b000:                 result = prod_s[31:0];
      3'b001, 3'b010, 3'b011: result = prod_s[63:32];
      3'b100:                 result = dz_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quo_s);
      3'b101:                 result = dz_q ? 32'hFFFF_FFFF : lo_q;
      3'b110:                 result = dz_q ? a_orig : (ovf_q ? 32'd0 : rem_s);
      3'b111:                 result = dz_q ? a_orig : hi_q;
      default:                result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    c_d      = c_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d  = S_CALC;
          cnt_d    = 6'd0;
          op_d     = op;
          sign_a_d = neg_a_in;
          sign_b_d = neg_b_in;
          dz_d     = (B == 32'd0);
          ovf_d    = op[2] && !op[0] && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
          a_mag_d  = a_abs_in;
          b_mag_d  = b_abs_in;
          hi_d     = 32'd0;
          // Multiply shifts the multiplier out of lo; divide shifts the dividend out
          lo_d     = op[2] ? a_abs_in : b_abs_in;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (op_q[2]) begin
            hi_d = div_hi_nxt;
            lo_d = div_lo_nxt;
          end else begin
            hi_d = mul_hi_nxt;
            lo_d = mul_lo_nxt;
          end
          if (cnt_q == 6'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          c_d     = result;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      c_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      c_q      <= c_d;
      valid_q  <= valid_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign valid = valid_q;
  assign C     = c_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed and random operations scored against a plain
// arithmetic model, plus handshake, flush and asynchronous-reset scenarios.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] C;

  mdu_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .valid (valid),
    .C     (C)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [31:0] exp_q[$];
  int          st_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] last_exp = '0;
  bit          prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: RV32M semantics in plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ua, ub, q;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = '0;
    case (o)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin q = sa / sb; r = q[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin q = ua / ub; r = q[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin q = sa % sb; r = q[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin q = ua % ub; r = q[31:0]; end
      end
    endcase
    return r;
  endfunction

  // Monitor: pops an expectation on every valid and checks latency and strobe shape
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid) begin
        chk("valid_one_cycle", 32'(valid), 32'd0);
        chk("busy_after_valid", 32'(busy), 32'd0);
      end
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL spurious_valid: C=%h with no request outstanding", C);
        end else begin
          chk("result", C, exp_q.pop_front());
          chk("latency", 32'(cyc - st_q.pop_front()), 32'd33);
        end
      end
      prev_valid = valid;
    end
  end

  // Driver tasks
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk_cnt++;
      $display("FAIL issue_timeout: busy=%b after %0d cycles, required 0", busy, n);
      return;
    end
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(ref_model(o, a, b));
      st_q.push_back(cyc + 1);
      last_exp = ref_model(o, a, b);
    end
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    op    = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      chk_cnt++;
      $display("FAIL %s: valid=%b after %0d cycles, required 1", name, valid, n);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[12];

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    A     = '0;
    B     = '0;
    dir = '{
      '{3'd0, 32'd7,         32'hFFFF_FFFD},
      '{3'd1, 32'h8000_0000, 32'h8000_0000},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF9, 32'd2},
      '{3'd6, 32'hFFFF_FFF9, 32'd2},
      '{3'd5, 32'd100,       32'd7},
      '{3'd7, 32'd100,       32'd7},
      '{3'd4, 32'd5,         32'd0},
      '{3'd7, 32'd5,         32'd0},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF}
    };

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_c", C, 32'd0);
    rst_n = 1'b1;

    foreach (dir[i]) issue(dir[i].o, dir[i].a, dir[i].b, 1'b1);

    // Starts while busy (CALC, then DONE) must be ignored
    issue(3'd5, 32'd1000, 32'd10, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    A     = $urandom;
    B     = $urandom;
    @(negedge clk);
    start = 1'b0;
    wait_valid("wait_done");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_ignored", 32'(busy), 32'd0);

    // Flush ten cycles into an operation
    issue(3'd0, 32'd5, 32'd6, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_c_hold", C, last_exp);
    repeat (40) @(negedge clk);
    chk("flush_c_after", C, last_exp);
    issue(3'd0, 32'd3, 32'd4, 1'b1);

    // Flush and start together in IDLE drop the request
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    flush = 1'b1;
    op    = 3'd0;
    A     = 32'd1;
    B     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_dropped", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1);
    end

    // Asynchronous reset in the middle of CALC
    issue(3'd0, 32'h1234, 32'h5678, 1'b1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    st_q.delete();
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_c", C, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd5, 32'd9, 32'd3, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the RV32M instructions that the single-cycle ALU does not implement. Sits beside the ALU in the execute stage. The control path issues one operation with a start pulse, stalls on `busy`, and collects `C` when `valid` pulses. Latency is a fixed 33 cycles for every operation, including the divide special cases.

## Interface
- No parameters. Data width is fixed at 32.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only in IDLE.
- `op` input 3: funct3 encoding.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A` input 32: rs1 operand. Multiplicand or dividend.
- `B` input 32: rs2 operand. Multiplier or divisor.
- `flush` input 1: abort the operation in flight (pipeline flush or trap).
- `busy` output 1: high whenever state is not IDLE.
- `valid` output 1: one-cycle result strobe.
- `C` output 32: result. Holds its value until the next result is written.

## Operation
- **States:** IDLE, CALC, FIX, DONE. `busy = (state != IDLE)`.
- **IDLE → CALC** on `start`. On that edge the unit latches:
  - `op`;
  - the operand signs;
  - the operand magnitudes, which are 32-bit unsigned absolute values;
  - the special-case flags `dz = (B==0)` and `ovf = signed DIV/REM && A==0x80000000 && B==0xFFFFFFFF`.
  - It also clears `cnt` (6 bits).
- **Operand signedness:**
  - Signed A: MULH, MULHSU, DIV, REM.
  - Signed B: MULH, DIV, REM.
  - MUL takes the low 32 bits, which do not depend on sign.
- **CALC:** one iteration per cycle; `cnt` increments each cycle. After 32 iterations the unit moves to FIX.
- **Multiply:** radix-2 shift-add on a 64-bit accumulator {hi, lo}. Each iteration:
  - if `lo[0]`, add the magnitude of A to hi with a 33-bit carry;
  - shift the 65-bit value right by 1.
- **Divide:** restoring division. Each iteration:
  - shift the {rem, quo} register left by 1;
  - trial-subtract the divisor magnitude from the 33-bit remainder;
  - if the result is non-negative, keep it and set `quo[0]=1`.
- **FIX:** one cycle. Applies sign correction and selects the result into `C`.
  - Product is negated as a 64-bit two's complement value if the operand signs differ.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - Quotient is negated if the dividend and divisor signs differ. Remainder takes the sign of the dividend.
  - `dz` overrides the result: DIV/DIVU return 0xFFFFFFFF; REM/REMU return A unchanged.
  - `ovf` overrides the result: DIV returns 0x80000000; REM returns 0.
  - Transitions to DONE.
- **DONE:** `valid=1` for exactly this cycle, then the unit returns to IDLE.
- **Start handling:**
  - `start` is ignored in every state except IDLE, including DONE.
  - The caller must hold `op`, `A` and `B` stable only during the cycle in which `start` is sampled.
- **Flush:** `flush=1` in CALC, FIX or DONE sends the unit to IDLE on the next edge.
  - `valid` stays low for the aborted operation and `C` keeps its previous value.
  - In IDLE, `flush` takes priority over `start`: the request is dropped.
- **Reset:**
  - State → IDLE; `busy=0`, `valid=0`, `C=0`.
  - All datapath registers and `cnt` clear to 0.
  - Reset asserted mid-operation aborts immediately, with no `valid`.

## Timing
- Edge N samples `start` in IDLE. `busy` is high from after N.
- Edges N+1..N+32 perform the 32 CALC iterations (`cnt` 0..31). Edge N+32 moves the state to FIX.
- Edge N+33 writes `C` and enters DONE. `valid` is high between N+33 and N+34.
- Edge N+34 returns to IDLE and `busy` drops. The earliest next start is sampled at N+35 if `start` is held.
- Latency from start to `valid` is 33 cycles. Issue interval is 35 cycles.
- `valid` and `C` are registered outputs with no combinational path from inputs. `busy` decodes from the state register only.

## Test plan
- **Multiply:**
  - MUL 7 × 0xFFFFFFFD → `C`=0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - Each of these: `valid` exactly 33 cycles after start.
- **Divide:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- **Special cases:**
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
  - All with the same 33-cycle latency.
- **Handshake:**
  - `start` pulsed with new operands while `busy` (CALC and DONE) → ignored; the first result is unchanged.
  - `valid` stays high for exactly 1 cycle.
  - `busy` falls exactly 1 cycle after `valid`.
- **Flush:**
  - `flush` 10 cycles after start → IDLE on the next edge, `busy`=0, no `valid`, `C` unchanged.
  - A subsequent MUL 3 × 4 → 12.
  - `flush` and `start` in the same IDLE cycle → no operation.
- **Reset:**
  - Deassert `rst_n` asynchronously mid-CALC → `busy`, `valid` and `C` are 0 immediately.
  - After release, DIVU 9 / 3 → 3 with normal latency.
